// File: rtl/fan_speed_sequencer_pkg.sv
// fan_pkg: shared timer encodings, level constants and widths for the fan speed sequencer.
package fan_pkg;

    localparam int REMAIN_W   = 15;
    localparam int LEVEL_BASE = 511;
    localparam int LEVEL_STEP = 512;

    typedef enum logic [3:0] {
        TMR_OFF = 4'b0001,
        TMR_1   = 4'b0010,
        TMR_2   = 4'b0100,
        TMR_3   = 4'b1000
    } timer_state_t;

    // Button cycles OFF -> T1 -> T2 -> T3 -> OFF.
    function automatic timer_state_t timer_next(input timer_state_t s);
        case (s)
            TMR_OFF: return TMR_1;
            TMR_1:   return TMR_2;
            TMR_2:   return TMR_3;
            default: return TMR_OFF;
        endcase
    endfunction

endpackage

// File: rtl/fan_speed_sequencer_if.sv
// fan_speed_sequencer_if: control inputs and status outputs between the button FSM, sequencer and PWM side.
interface fan_speed_sequencer_if #(
    parameter int N = 12
);
    import fan_pkg::*;

    // No valid/ready here: fan_en/speed_req are levels, the *_btn_p inputs are single-cycle
    // pulses, all sampled on posedge clk; every output is registered in the sequencer.
    logic                fan_en;
    logic [2:0]          speed_req;
    logic                timer_btn_p;
    logic                breeze_btn_p;
    logic [N-1:0]        duty;
    logic [3:0]          timer_state;
    logic [REMAIN_W-1:0] remain_sec;
    logic                ramping;
    logic                timer_expired;

    modport master (
        output fan_en, speed_req, timer_btn_p, breeze_btn_p,
        input  duty, timer_state, remain_sec, ramping, timer_expired
    );

    modport slave (
        input  fan_en, speed_req, timer_btn_p, breeze_btn_p,
        output duty, timer_state, remain_sec, ramping, timer_expired
    );

endinterface

// File: rtl/fan_speed_sequencer_tick_gen.sv
// fan_tick_gen: microsecond, ramp-step and second strobes derived from the system clock.
module fan_tick_gen #(
    parameter int SYS_FREQ = 125,
    parameter int RAMP_US  = 1000,
    parameter int SEC_US   = 1000000
) (
    input  logic clk,
    input  logic reset_p,
    input  logic sec_restart,
    output logic us_tick,
    output logic ramp_tick,
    output logic sec_tick
);

    localparam int US_W   = (SYS_FREQ > 1) ? $clog2(SYS_FREQ) : 1;
    localparam int RAMP_W = (RAMP_US > 1) ? $clog2(RAMP_US) : 1;
    localparam int SEC_W  = (SEC_US > 1) ? $clog2(SEC_US) : 1;

    logic [US_W-1:0]   us_cnt;
    logic [RAMP_W-1:0] ramp_cnt;
    logic [SEC_W-1:0]  sec_cnt;

    assign us_tick   = (us_cnt == US_W'(SYS_FREQ - 1));
    assign ramp_tick = us_tick && (ramp_cnt == RAMP_W'(RAMP_US - 1));
    assign sec_tick  = us_tick && (sec_cnt == SEC_W'(SEC_US - 1));

    // A restart still lets a coincident sec_tick through so the countdown never loses a second.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            us_cnt   <= '0;
            ramp_cnt <= '0;
            sec_cnt  <= '0;
        end else begin
            if (us_tick) us_cnt <= '0;
            else         us_cnt <= us_cnt + 1'b1;

            if (ramp_tick)    ramp_cnt <= '0;
            else if (us_tick) ramp_cnt <= ramp_cnt + 1'b1;

            if (sec_restart || sec_tick) sec_cnt <= '0;
            else if (us_tick)            sec_cnt <= sec_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fan_speed_sequencer.sv
// fan_speed_sequencer: soft-ramps duty toward the requested speed level and runs the off-timer.
// Breeze modulation (alternating full/half duty) is built only when FAN_BREEZE_EN is defined.
module fan_speed_sequencer
    import fan_pkg::*;
#(
    parameter int SYS_FREQ  = 125,
    parameter int N         = 12,
    parameter int RAMP_US   = 1000,
    parameter int RAMP_STEP = 16,
    parameter int SEC_US    = 1000000,
    parameter int T1_SEC    = 3600,
    parameter int T2_SEC    = 10800,
    parameter int T3_SEC    = 18000
) (
    input logic clk,
    input logic reset_p,
    fan_speed_sequencer_if.slave bus
);

    localparam logic [N-1:0] FULL   = {N{1'b1}};
    localparam logic [N:0]   STEP_W = (N+1)'(RAMP_STEP);
    localparam logic [N-1:0] STEP_N = N'(RAMP_STEP);

    logic us_tick, ramp_tick, sec_tick;
    logic ramp_now, sec_now;

    fan_tick_gen #(
        .SYS_FREQ(SYS_FREQ),
        .RAMP_US (RAMP_US),
        .SEC_US  (SEC_US)
    ) u_tick (
        .clk        (clk),
        .reset_p    (reset_p),
        .sec_restart(bus.timer_btn_p),
        .us_tick    (us_tick),
        .ramp_tick  (ramp_tick),
        .sec_tick   (sec_tick)
    );

    assign ramp_now = ramp_tick & us_tick;
    assign sec_now  = sec_tick;

    logic [N-1:0]        duty_q, target_q;
    logic                ramping_q, expired_q, stop_q;
    logic [2:0]          speed_prev_q;
    timer_state_t        state_q, state_adv;
    logic [REMAIN_W-1:0] remain_q, preset;

    logic [N:0]   lvl_wide;
    logic [N-1:0] lvl, eff_lvl, target_nxt, duty_nxt;
    logic         expire, speed_chg;

`ifdef FAN_BREEZE_EN
    logic       breeze_q, half_q;
    logic [1:0] phase_q;

    // Turning breeze on always starts on the full-duty phase.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            breeze_q <= 1'b0;
            half_q   <= 1'b0;
            phase_q  <= '0;
        end else if (!bus.fan_en) begin
            breeze_q <= 1'b0;
        end else if (bus.breeze_btn_p) begin
            breeze_q <= !breeze_q;
            if (!breeze_q) begin
                half_q  <= 1'b0;
                phase_q <= '0;
            end
        end else if (breeze_q && sec_now) begin
            phase_q <= phase_q + 1'b1;
            if (phase_q == 2'd3) half_q <= !half_q;
        end
    end
`else
    logic unused_breeze;
    assign unused_breeze = bus.breeze_btn_p;
`endif

    always_comb begin
        lvl_wide = (N+1)'(LEVEL_STEP * int'(bus.speed_req) + LEVEL_BASE);
        lvl      = (lvl_wide > {1'b0, FULL}) ? FULL : lvl_wide[N-1:0];
        eff_lvl  = lvl;
`ifdef FAN_BREEZE_EN
        if (breeze_q && half_q) eff_lvl = lvl >> 1;
`endif
        target_nxt = (bus.fan_en && !stop_q && bus.speed_req != 3'd0) ? eff_lvl : '0;

        // Differences are formed only in the direction that cannot underflow.
        duty_nxt = duty_q;
        if (!bus.fan_en) begin
            duty_nxt = '0;
        end else if (ramp_now) begin
            if (duty_q < target_q)
                duty_nxt = ({1'b0, target_q - duty_q} > STEP_W) ? duty_q + STEP_N : target_q;
            else if (duty_q > target_q)
                duty_nxt = ({1'b0, duty_q - target_q} > STEP_W) ? duty_q - STEP_N : target_q;
        end
    end

    always_comb begin
        state_adv = timer_next(state_q);
        case (state_adv)
            TMR_1:   preset = REMAIN_W'(T1_SEC);
            TMR_2:   preset = REMAIN_W'(T2_SEC);
            TMR_3:   preset = REMAIN_W'(T3_SEC);
            default: preset = '0;
        endcase
    end

    assign expire    = bus.fan_en && (state_q != TMR_OFF) && sec_now && (remain_q == REMAIN_W'(1));
    assign speed_chg = (bus.speed_req != speed_prev_q);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            duty_q       <= '0;
            target_q     <= '0;
            ramping_q    <= 1'b0;
            expired_q    <= 1'b0;
            stop_q       <= 1'b0;
            speed_prev_q <= '0;
            state_q      <= TMR_OFF;
            remain_q     <= '0;
        end else begin
            duty_q       <= duty_nxt;
            target_q     <= target_nxt;
            ramping_q    <= (duty_nxt != target_nxt);
            speed_prev_q <= bus.speed_req;
            expired_q    <= expire;

            // Expiry outranks a button press landing in the same cycle.
            if (!bus.fan_en || expire) begin
                state_q  <= TMR_OFF;
                remain_q <= '0;
            end else if (bus.timer_btn_p) begin
                state_q  <= state_adv;
                remain_q <= preset;
            end else if (sec_now && state_q != TMR_OFF && remain_q != '0) begin
                remain_q <= remain_q - 1'b1;
            end

            if (expire)                                        stop_q <= 1'b1;
            else if (!bus.fan_en || bus.timer_btn_p || speed_chg) stop_q <= 1'b0;
        end
    end

    assign bus.duty          = duty_q;
    assign bus.timer_state   = state_q;
    assign bus.remain_sec    = remain_q;
    assign bus.ramping       = ramping_q;
    assign bus.timer_expired = expired_q;

endmodule

// File: doc/fan_speed_sequencer.md
Name: fan_speed_sequencer

Overview:
Sits between the button-driven speed-level FSM and the PWM generator. Converts a requested speed level (0-7) into a soft-ramped duty word, so the motor never sees a duty step larger than RAMP_STEP. Also implements a button-cycled off-timer (off / T1 / T2 / T3) that counts down in seconds and forces the fan to stop on expiry.

Parameters:
SYS_FREQ, 125, system clock in MHz (cycles per microsecond)
N, 12, duty width; full scale 2^N-1
RAMP_US, 1000, microseconds between ramp steps
RAMP_STEP, 16, maximum duty change per ramp step
SEC_US, 1000000, microseconds per timer second (reduced in simulation)
T1_SEC, 3600, first timer preset in seconds
T2_SEC, 10800, second timer preset in seconds
T3_SEC, 18000, third timer preset in seconds (must be < 2^15)

Ports:
clk  in  1  system clock
reset_p  in  1  asynchronous active-high reset
fan_en  in  1  master enable; 0 = fan stopped
speed_req  in  3  requested level; 0 = off, 1..7 = speeds
timer_btn_p  in  1  one-cycle pulse; advances the timer preset
breeze_btn_p  in  1  one-cycle pulse; toggles breeze mode (see Optional Feature)
duty  out  N  ramped duty word to the PWM controller
timer_state  out  4  one-hot: 0001 OFF, 0010 T1, 0100 T2, 1000 T3
remain_sec  out  15  seconds remaining; 0 when the timer is OFF
ramping  out  1  high while duty != target
timer_expired  out  1  one-cycle pulse when the countdown reaches 0

Behaviour:
- Reset values: duty=0, timer_state=0001, remain_sec=0, ramping=0, timer_expired=0, stop latch=0, breeze=0. All flops use posedge clk.
- us tick: one-cycle pulse every SYS_FREQ cycles. ramp tick: every RAMP_US us ticks. sec tick: every SEC_US us ticks. The sec prescaler restarts on every timer_btn_p.
- Target (registered, 1-cycle latency):
  - 0 if fan_en=0, or stop latch=1, or speed_req=0.
  - Otherwise 512*speed_req+511, giving 1023, 1535 ... 4095 for N=12.
  - Computed in N+1 bits, then saturated to 2^N-1.
- Ramp: on each ramp tick, if duty<target then duty=min(duty+RAMP_STEP, target); if duty>target then duty=max(duty-RAMP_STEP, target). The comparison must not wrap below 0 or above full scale.
- ramping = (duty != target), registered.
- fan_en falling: duty is cleared to 0 on the next cycle with no ramp (safety); the timer is forced to OFF and remain_sec to 0.
- Timer FSM (active only when fan_en=1):
  - timer_btn_p advances OFF->T1->T2->T3->OFF.
  - Entering Tk loads remain_sec with TkSEC. Entering OFF loads 0.
  - In T1..T3, each sec tick decrements remain_sec.
  - When remain_sec goes 1->0: timer_expired pulses, timer_state returns to OFF, and the stop latch is set.
- Stop latch: cleared when speed_req changes value, or on timer_btn_p, or when fan_en=0.
- Simultaneous events:
  - Expiry beats timer_btn_p in the same cycle; the button press is dropped.
  - timer_btn_p with speed_req=0 is still accepted.
- Reset mid-ramp or mid-countdown returns all state to reset values immediately (asynchronous).

Optional Feature:
Macro FAN_BREEZE_EN.
- Defined:
  - breeze_btn_p toggles the breeze flag while fan_en=1; fan_en=0 clears it.
  - While breeze is set and the target is nonzero, the effective target alternates every 4 sec ticks between the full level duty and half of it (right-shift by 1).
  - The phase counter starts on the full-duty phase whenever breeze is enabled.
  - The ramp applies normally to each alternation.
- Not defined: breeze_btn_p is ignored, breeze logic is absent, and the target is always the full level duty.

Decomposition:
- Package fan_pkg holds:
  - timer one-hot encodings (TMR_OFF, TMR_1, TMR_2, TMR_3);
  - the LEVEL_BASE=511 and LEVEL_STEP=512 constants;
  - the remain_sec width constant (15).
- Sub-module fan_tick_gen: parameters SYS_FREQ, RAMP_US, SEC_US; outputs us_tick, ramp_tick, sec_tick; has a sync restart input for the sec prescaler.

Test Plan:
- Bench parameters for all scenarios: SYS_FREQ=1, RAMP_US=2, RAMP_STEP=512, SEC_US=10, T1_SEC=3.
- Ramp up: fan_en=1, speed_req 0->7 -> duty steps 512, 1024 ... 3584, 4095, one step every 2 cycles; ramping drops to 0 once duty=4095.
- Ramp down with no overshoot: at duty 4095, speed_req=1 -> duty steps 3583, 3071 ... 1535, 1023, then holds; never below 1023.
- Safety cut: at duty 2047, drop fan_en -> duty=0 the next cycle; timer_state=0001; remain_sec=0.
- Timer expiry:
  - timer_btn_p once -> timer_state=0010, remain_sec=3, decrementing every 10 cycles.
  - At 0: timer_expired pulses once, timer_state=0001, and duty ramps to 0.
  - Then a change of speed_req restarts the ramp.
- Collision: timer_btn_p asserted in the same cycle as the 1->0 decrement -> timer_state=0001 and the press is ignored.
- Breeze (FAN_BREEZE_EN only): level 7, breeze on -> target alternates 4095/2047 every 40 cycles; with the macro undefined, duty stays at 4095.
